// File: rtl/aesl_deadlock_pkg.sv
// Shared types and widths for the deadlock report controller.
package aesl_deadlock_pkg;

  localparam int STAMP_W = 32;
  localparam int PCNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    QUALIFY,
    ARB,
    SEND,
    DONE
  } state_e;

endpackage

// File: rtl/aesl_rr_pick.sv
// Round-robin picker: first set pending bit at or after rr_ptr, wrapping at N_MON.
module aesl_rr_pick #(
  parameter int N_MON = 4,
  parameter int IDX_W = $clog2(N_MON)
) (
  input  logic [N_MON-1:0] pending,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    // Walk from the farthest candidate back to rr_ptr so the nearest set bit wins.
    for (int k = N_MON - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_MON);
      if (pending[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aesl_deadlock_report_ctrl.sv
// Qualifies persistent monitor blocking, snapshots it, and reports each blocked monitor once.
// Define AESL_DEADLOCK_STAMP_EN to add a 32-bit cycle counter and the rpt_cycle stamp output.
module aesl_deadlock_report_ctrl
  import aesl_deadlock_pkg::*;
#(
  parameter int N_MON   = 4,
  parameter int INFO_W  = 4,
  parameter int PERSIST = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_MON-1:0]          mon_block,
  input  logic [N_MON*INFO_W-1:0]   mon_info,
  output logic                      rpt_valid,
  input  logic                      rpt_ready,
  output logic [$clog2(N_MON)-1:0]  rpt_idx,
  output logic [INFO_W-1:0]         rpt_info,
  output logic                      deadlock,
  output logic                      busy
`ifdef AESL_DEADLOCK_STAMP_EN
  ,
  output logic [STAMP_W-1:0]        rpt_cycle
`endif
);

  localparam int IDX_W = $clog2(N_MON);
  localparam logic [PCNT_W-1:0] PERSIST_C = PCNT_W'(PERSIST);

  state_e              state_q;
  logic [PCNT_W-1:0]   persist_cnt_q;
  logic [N_MON-1:0]    pending_q;
  logic [IDX_W-1:0]    rr_ptr_q;
  logic [INFO_W-1:0]   info_snap_q [N_MON];
  logic                rpt_valid_q;
  logic [IDX_W-1:0]    rpt_idx_q;
  logic [INFO_W-1:0]   rpt_info_q;
  logic                deadlock_q;
  logic                busy_q;

  logic                any_block;
  logic [PCNT_W-1:0]   cnt_inc;
  logic                snap;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  assign any_block = |mon_block;
  assign cnt_inc   = (persist_cnt_q == '1) ? persist_cnt_q : persist_cnt_q + 1'b1;
  assign snap      = any_block &&
                     ((state_q == IDLE && PERSIST == 1) ||
                      (state_q == QUALIFY && cnt_inc == PERSIST_C));

  aesl_rr_pick #(
    .N_MON (N_MON),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .pending (pending_q),
    .rr_ptr  (rr_ptr_q),
    .idx     (pick_idx),
    .any     (pick_any)
  );

  // NOTE: the info snapshot array has no reset; it is rewritten at every snapshot before anything reads it.
  always_ff @(posedge clock) begin
    if (!reset && snap) begin
      for (int i = 0; i < N_MON; i++) begin
        info_snap_q[i] <= mon_info[i*INFO_W +: INFO_W];
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      persist_cnt_q <= '0;
      pending_q     <= '0;
      rr_ptr_q      <= '0;
      rpt_valid_q   <= 1'b0;
      rpt_idx_q     <= '0;
      rpt_info_q    <= '0;
      deadlock_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (any_block) begin
            persist_cnt_q <= PCNT_W'(1);
            busy_q        <= 1'b1;
            if (snap) begin
              pending_q <= mon_block;
              state_q   <= ARB;
            end else begin
              state_q   <= QUALIFY;
            end
          end
        end
        QUALIFY: begin
          if (!any_block) begin
            persist_cnt_q <= '0;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else begin
            persist_cnt_q <= cnt_inc;
            if (snap) begin
              pending_q <= mon_block;
              state_q   <= ARB;
            end
          end
        end
        ARB: begin
          if (pick_any) begin
            rpt_idx_q   <= pick_idx;
            rpt_info_q  <= info_snap_q[pick_idx];
            rpt_valid_q <= 1'b1;
            state_q     <= SEND;
          end else begin
            deadlock_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end
        end
        SEND: begin
          if (rpt_ready) begin
            pending_q[rpt_idx_q] <= 1'b0;
            rr_ptr_q    <= (rpt_idx_q == IDX_W'(N_MON - 1)) ? '0 : rpt_idx_q + 1'b1;
            rpt_valid_q <= 1'b0;
            state_q     <= ARB;
          end
        end
        DONE: begin
          // Sticky until reset; monitor activity is ignored.
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rpt_valid = rpt_valid_q;
  assign rpt_idx   = rpt_idx_q;
  assign rpt_info  = rpt_info_q;
  assign deadlock  = deadlock_q;
  assign busy      = busy_q;

`ifdef AESL_DEADLOCK_STAMP_EN
  logic [STAMP_W-1:0] cycle_cnt_q;
  logic [STAMP_W-1:0] rpt_cycle_q;

  // The stamp is taken once at the snapshot, so every report of an episode shares it.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      rpt_cycle_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (snap) begin
        rpt_cycle_q <= cycle_cnt_q;
      end
    end
  end

  assign rpt_cycle = rpt_cycle_q;
`endif

endmodule

// File: tb/tb_aesl_deadlock_report_ctrl.sv
// Self-checking bench: directed episodes plus randomized traffic against a behavioural model.
module tb_aesl_deadlock_report_ctrl;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int P  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  mon_block = '0;
  logic [N*IW-1:0] mon_info = '0;
  logic          rpt_ready = 1'b0;
  logic          rpt_valid;
  logic [1:0]    rpt_idx;
  logic [IW-1:0] rpt_info;
  logic          deadlock;
  logic          busy;
`ifdef AESL_DEADLOCK_STAMP_EN
  logic [31:0]   rpt_cycle;
`endif

  aesl_deadlock_report_ctrl #(
    .N_MON   (N),
    .INFO_W  (IW),
    .PERSIST (P)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mon_block (mon_block),
    .mon_info  (mon_info),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_idx   (rpt_idx),
    .rpt_info  (rpt_info),
    .deadlock  (deadlock),
    .busy      (busy)
`ifdef AESL_DEADLOCK_STAMP_EN
    ,
    .rpt_cycle (rpt_cycle)
`endif
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0 = watching, 1 = reporting, 2 = deadlock declared.
  int          m_mode;
  int          m_run;
  bit [N-1:0]  m_pend;
  logic [IW-1:0] m_info [N];
  int          m_ptr;
  bit          m_valid;
  int          m_cur;
  int unsigned m_cyc;
  int unsigned m_stamp;
  bit          m_just_reset;
  int          m_reports;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    m_just_reset = 1'b0;
    if (reset) begin
      m_mode = 0; m_run = 0; m_pend = '0; m_ptr = 0;
      m_valid = 1'b0; m_cur = 0; m_cyc = 0; m_stamp = 0;
      m_just_reset = 1'b1;
      return;
    end
    case (m_mode)
      0: begin
        if (|mon_block) begin
          m_run++;
          if (m_run >= P) begin
            m_pend = mon_block;
            for (int i = 0; i < N; i++) m_info[i] = mon_info[i*IW +: IW];
            m_stamp = m_cyc;
            m_mode  = 1;
            m_run   = 0;
            m_valid = 1'b0;
          end
        end else begin
          m_run = 0;
        end
      end
      1: begin
        if (m_valid) begin
          if (rpt_ready) begin
            m_pend[m_cur] = 1'b0;
            m_ptr   = (m_cur + 1) % N;
            m_valid = 1'b0;
            m_reports++;
          end
        end else if (m_pend == '0) begin
          m_mode = 2;
        end else begin
          for (int k = N - 1; k >= 0; k--) begin
            if (m_pend[(m_ptr + k) % N]) m_cur = (m_ptr + k) % N;
          end
          m_valid = 1'b1;
        end
      end
      default: ;
    endcase
    m_cyc++;
  endtask

  task automatic compare_all();
    check("rpt_valid", 32'(rpt_valid), 32'(m_valid));
    check("deadlock",  32'(deadlock),  32'(m_mode == 2));
    check("busy",      32'(busy),      32'(m_mode == 1 || (m_mode == 0 && m_run > 0)));
    if (m_valid) begin
      check("rpt_idx",  32'(rpt_idx),  32'(m_cur));
      check("rpt_info", 32'(rpt_info), 32'(m_info[m_cur]));
    end else if (m_just_reset) begin
      check("rst_idx",  32'(rpt_idx),  32'd0);
      check("rst_info", 32'(rpt_info), 32'd0);
    end
`ifdef AESL_DEADLOCK_STAMP_EN
    check("rpt_cycle", rpt_cycle, m_stamp);
`endif
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] blk;

    // Reset state, then a single blocked monitor.
    do_reset();
    step();
    rpt_ready = 1'b1;
    mon_block = 4'b0010;
    mon_info  = 16'hA5C3;
    repeat (P) step();
    mon_block = '0;
    mon_info  = 16'h1234;
    m_reports = 0;
    repeat (10) step();
    check("single_reports", 32'(m_reports), 32'd1);

    // Glitch shorter than the persistence window.
    do_reset();
    mon_block = 4'b0100;
    repeat (P - 1) step();
    mon_block = '0;
    repeat (8) step();
    check("glitch_no_dl", 32'(deadlock), 32'd0);

    // Backpressure with three pending monitors.
    do_reset();
    rpt_ready = 1'b0;
    mon_block = 4'b1011;
    mon_info  = 16'h9E71;
    repeat (P) step();
    mon_block = 4'b0000;
    mon_info  = 16'hFFFF;
    repeat (12) step();
    rpt_ready = 1'b1;
    m_reports = 0;
    repeat (10) step();
    check("bp_reports", 32'(m_reports), 32'd3);

    // Reset while a report is being presented.
    do_reset();
    rpt_ready = 1'b0;
    mon_block = 4'b1110;
    repeat (P + 1) step();
    check("pre_rst_valid", 32'(rpt_valid), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    mon_block = 4'b0011;
    mon_info  = 16'h4321;
    repeat (P + 1) step();
    check("post_rst_idx", 32'(rpt_idx), 32'd0);
    rpt_ready = 1'b1;
    repeat (8) step();

    // Randomized episodes.
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      blk = 4'($urandom_range(1, 15));
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 99) < 15) blk = 4'($urandom_range(0, 15));
        mon_block = blk;
        mon_info  = 16'($urandom);
        rpt_ready = 1'($urandom_range(0, 1));
        reset     = ($urandom_range(0, 99) < 2);
        step();
      end
      reset = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aesl_deadlock_report_ctrl.md
AESL_DEADLOCK_REPORT_CTRL -- requirements
Module: aesl_deadlock_report_ctrl

Interface
- REQ-001: Parameter N_MON, default 4: number of deadlock monitors served; legal range 2..16.
- REQ-002: Parameter INFO_W, default 4: width of each monitor's axis block-info field.
- REQ-003: Parameter PERSIST, default 16: consecutive blocked cycles needed before reporting; legal range 1..65535.
- REQ-004: Port clock, input, 1: sole clock; all state changes on its rising edge.
- REQ-005: Port reset, input, 1: synchronous, active-high reset.
- REQ-006: Port mon_block, input, N_MON: per-monitor block flag; bit i comes from monitor i.
- REQ-007: Port mon_info, input, N_MON*INFO_W: per-monitor axis block info; monitor i occupies bits [i*INFO_W +: INFO_W].
- REQ-008: Port rpt_valid, output, 1: a report is presented.
- REQ-009: Port rpt_ready, input, 1: the consumer accepts the report.
- REQ-010: Port rpt_idx, output, clog2(N_MON): index of the reported monitor.
- REQ-011: Port rpt_info, output, INFO_W: snapshotted info of the reported monitor.
- REQ-012: Port rpt_cycle, output, 32: cycle stamp; present only when AESL_DEADLOCK_STAMP_EN is defined.
- REQ-013: Port deadlock, output, 1: sticky flag; all reports have been delivered.
- REQ-014: Port busy, output, 1: high in every state except IDLE and DONE.

Function
- REQ-015: FSM states are IDLE, QUALIFY, ARB, SEND and DONE.
- REQ-016: IDLE: if |mon_block is sampled high, go to QUALIFY with persist_cnt=1; otherwise stay in IDLE.
- REQ-017: QUALIFY: if |mon_block is low, return to IDLE with persist_cnt=0; otherwise increment persist_cnt (16-bit, saturating).
- REQ-018: QUALIFY snapshot: on the edge where the PERSIST-th consecutive high sample is taken, capture pending=mon_block and info_snap=mon_info, then go to ARB.
- REQ-019: PERSIST=1: the snapshot occurs at the first high sample, and the FSM goes directly IDLE->ARB.
- REQ-020: ARB (one cycle): round-robin pick of the first set pending bit at index >= rr_ptr, wrapping at N_MON; load rpt_idx and rpt_info; go to SEND. If pending==0, go to DONE.
- REQ-021: SEND: rpt_valid=1, and rpt_idx, rpt_info and rpt_cycle stay stable until the handshake.
- REQ-022: Handshake: rpt_valid&&rpt_ready clears pending[rpt_idx], sets rr_ptr=(rpt_idx+1) mod N_MON, and returns to ARB; rpt_valid is low in ARB.
- REQ-023: rpt_ready while rpt_valid is low has no effect.
- REQ-024: Latency: rpt_valid first rises 2 cycles after the snapshot edge, and reports are spaced at least 2 cycles apart.
- REQ-025: After the snapshot, mon_block/mon_info changes are ignored; a monitor that deasserts before its turn is still reported.
- REQ-026: DONE: deadlock=1 and rpt_valid=0 until reset; new mon_block activity is ignored.
- REQ-027: rr_ptr persists across episodes; it is cleared only by reset.

Reset
- REQ-028: Reset values: state=IDLE, persist_cnt=0, pending=0, rr_ptr=0, rpt_valid=0, rpt_idx=0, rpt_info=0, deadlock=0, busy=0, and (if present) rpt_cycle=0 and cycle counter=0.
- REQ-029: Reset asserted mid-SEND drops rpt_valid on the next edge; the report is lost and not replayed.
- REQ-030: Reset has priority over every other state update.

Configuration
- REQ-031: Macro AESL_DEADLOCK_STAMP_EN defined: a free-running 32-bit wrapping cycle counter is built. rpt_cycle carries its value at the snapshot edge, and that value is identical for all reports of the episode.
- REQ-032: Macro AESL_DEADLOCK_STAMP_EN undefined: no counter and no rpt_cycle port exist; all other behaviour is unchanged.

Structure
- REQ-033: Package aesl_deadlock_pkg holds the FSM state enum, the cycle stamp width constant (32) and the persist counter width constant (16).
- REQ-034: Round-robin selection lives in sub-module aesl_rr_pick (inputs: pending, rr_ptr; outputs: idx, any). It is purely combinational and instantiated once.

Verification
- REQ-035: Single monitor. PERSIST=4, mon_block=4'b0010 held for 4 cycles -> one report: rpt_idx=1, rpt_info=snapshot value; then deadlock=1 and stays high.
- REQ-036: Glitch reject. PERSIST=4, mon_block high for 3 cycles then low -> state returns to IDLE, no rpt_valid, deadlock stays 0.
- REQ-037: Round robin. rr_ptr=2 from a prior episode, snapshot pending=4'b1011 -> report order is 3, 0, 1; then deadlock=1.
- REQ-038: Backpressure. rpt_ready is held low for 10 cycles during SEND -> rpt_valid, rpt_idx and rpt_info are stable all 10 cycles; the next report follows 2 cycles after the handshake.
- REQ-039: Reset mid-SEND. Reset asserted while rpt_valid=1 -> rpt_valid=0 and deadlock=0 on the next edge, rr_ptr=0, and a new episode reports from index 0.
- REQ-040: Stamp build. With AESL_DEADLOCK_STAMP_EN and the snapshot at cycle 100 -> every report of the episode has rpt_cycle=100, including across counter wrap.
